// File: rtl/traffic_intersection_ctrl.sv
// Round-robin multi-group intersection controller: green, green-blink, yellow and all-red
// phases per group, request-driven green shortening, and yellow-flash mode while disabled.
module traffic_intersection_ctrl #(
    parameter int N_DIR      = 3,
    parameter int TICK_DIV   = 1,
    parameter int GREEN_ON   = 40,
    parameter int MIN_GREEN  = 10,
    parameter int BLINK      = 3,
    parameter int BLINK_HALF = 2,
    parameter int YELLOW_ON  = 5,
    parameter int ALL_RED    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en_i,
    input  logic [N_DIR-1:0]                       req_i,
    output logic [3*N_DIR-1:0]                     color_out,
    output logic [((N_DIR > 1) ? $clog2(N_DIR) : 1)-1:0] phase_o,
    output logic                                   flash_o
);

    localparam int PHW     = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam int BLINK_T = 2 * BLINK * BLINK_HALF;
    localparam int FLASH_T = 2 * BLINK_HALF;
    localparam int M1      = (GREEN_ON > BLINK_T) ? GREEN_ON : BLINK_T;
    localparam int M2      = (YELLOW_ON > ALL_RED) ? YELLOW_ON : ALL_RED;
    localparam int M3      = (M1 > M2) ? M1 : M2;
    localparam int TMAX    = (M3 > FLASH_T) ? M3 : FLASH_T;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    typedef enum logic [2:0] {
        S_ALL_RED,
        S_GREEN,
        S_GBLINK,
        S_YELLOW,
        S_FLASH
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PHW-1:0]       phase_q, phase_d;
    logic [N_DIR-1:0]     pend_q, pend_d;
    logic                 first_q, first_d;
    logic [3*N_DIR-1:0]   color_q;
    logic                 flash_q;
    logic                 tick;
    logic                 busy;
    logic                 others_pending;
    logic [N_DIR-1:0]     act_mask;

    function automatic logic [N_DIR-1:0] onehot(input logic [PHW-1:0] p);
        return N_DIR'(1) << p;
    endfunction

    // Blink/flash patterns are lit during the first half of each full period.
    function automatic logic lit(input logic [TW-1:0] t);
        logic [TW-1:0] half_idx;
        half_idx = t / TW'(BLINK_HALF);
        return ~half_idx[0];
    endfunction

    function automatic logic [3*N_DIR-1:0] lamps(input state_t st, input logic [PHW-1:0] ph,
                                                 input logic [TW-1:0] t);
        logic [3*N_DIR-1:0] v;
        logic [2:0]         g;
        v = '0;
        for (int k = 0; k < N_DIR; k++) begin
            g = LAMP_RED;
            if (st == S_FLASH) begin
                g = lit(t) ? LAMP_YELLOW : LAMP_DARK;
            end else if (k == int'(ph)) begin
                case (st)
                    S_GREEN:  g = LAMP_GREEN;
                    S_GBLINK: g = lit(t) ? LAMP_GREEN : LAMP_DARK;
                    S_YELLOW: g = LAMP_YELLOW;
                    default:  g = LAMP_RED;
                endcase
            end
            v[3*k +: 3] = g;
        end
        return v;
    endfunction

    assign tick           = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d        = tick ? '0 : presc_q + 1'b1;
    assign busy           = (state_q == S_GREEN) || (state_q == S_GBLINK) || (state_q == S_YELLOW);
    assign act_mask       = onehot(phase_q);
    assign others_pending = |(pend_q & ~act_mask);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        phase_d = phase_q;
        first_d = first_q;
        pend_d  = pend_q | (req_i & ~(busy ? act_mask : '0));

        // Mode changes are honoured on the very next edge, independent of the prescaler.
        if (state_q != S_FLASH && !en_i) begin
            state_d = S_FLASH;
            timer_d = '0;
        end else if (state_q == S_FLASH && en_i) begin
            state_d = S_ALL_RED;
            timer_d = '0;
            phase_d = '0;
            first_d = 1'b1;
        end else if (tick) begin
            timer_d = timer_q + 1'b1;
            case (state_q)
                S_ALL_RED: begin
                    if (timer_q == TW'(ALL_RED - 1)) begin
                        state_d = S_GREEN;
                        timer_d = '0;
                        first_d = 1'b0;
                        if (!first_q)
                            phase_d = (phase_q == PHW'(N_DIR - 1)) ? '0 : phase_q + 1'b1;
                    end
                end
                S_GREEN: begin
                    if (timer_q == TW'(GREEN_ON - 1) ||
                        (timer_q >= TW'(MIN_GREEN - 1) && others_pending)) begin
                        state_d = (BLINK > 0) ? S_GBLINK : S_YELLOW;
                        timer_d = '0;
                    end
                end
                S_GBLINK: begin
                    if (timer_q == TW'(BLINK_T - 1)) begin
                        state_d = S_YELLOW;
                        timer_d = '0;
                    end
                end
                S_YELLOW: begin
                    if (timer_q == TW'(YELLOW_ON - 1)) begin
                        state_d = S_ALL_RED;
                        timer_d = '0;
                    end
                end
                S_FLASH: begin
                    if (timer_q == TW'(FLASH_T - 1))
                        timer_d = '0;
                end
                default: begin
                    state_d = S_ALL_RED;
                    timer_d = '0;
                end
            endcase
        end

        // Entering green consumes that group's demand; this overrides a same-edge request.
        if (state_d == S_GREEN && state_q != S_GREEN)
            pend_d = pend_d & ~onehot(phase_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ALL_RED;
            presc_q <= '0;
            timer_q <= '0;
            phase_q <= '0;
            pend_q  <= '0;
            first_q <= 1'b1;
            color_q <= {N_DIR{LAMP_RED}};
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            color_q <= lamps(state_d, phase_d, timer_d);
            flash_q <= (state_d == S_FLASH);
        end
    end

    assign color_out = color_q;
    assign phase_o   = phase_q;
    assign flash_o   = flash_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios plus randomized requests/enable/reset,
// compared every cycle against a segment/age model of the intersection rules.
module tb_traffic_intersection_ctrl;

    localparam int SEG_CLR = 0;
    localparam int SEG_GRN = 1;
    localparam int SEG_BLK = 2;
    localparam int SEG_YEL = 3;
    localparam int SEG_FL  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [2:0] req = 3'b000;
    logic [8:0] color;
    logic [1:0] phase;
    logic       flash;

    logic       rst6 = 1'b1;
    logic       en6  = 1'b1;
    logic [2:0] req6 = 3'b000;
    logic [8:0] color6;
    logic [1:0] phase6;
    logic       flash6;

    int checks = 0;
    int errors = 0;

    int       m_seg = SEG_CLR;
    int       m_age = 0;
    int       m_phase = 0;
    bit       m_first = 1'b1;
    bit [2:0] m_pend = 3'b000;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .N_DIR(3), .TICK_DIV(1), .GREEN_ON(8), .MIN_GREEN(3), .BLINK(2),
        .BLINK_HALF(2), .YELLOW_ON(3), .ALL_RED(2)
    ) u_dut (
        .clk(clk), .rst(rst), .en_i(en), .req_i(req),
        .color_out(color), .phase_o(phase), .flash_o(flash)
    );

    traffic_intersection_ctrl #(
        .N_DIR(3), .TICK_DIV(4), .GREEN_ON(8), .MIN_GREEN(3), .BLINK(0),
        .BLINK_HALF(2), .YELLOW_ON(3), .ALL_RED(2)
    ) u_dut6 (
        .clk(clk), .rst(rst6), .en_i(en6), .req_i(req6),
        .color_out(color6), .phase_o(phase6), .flash_o(flash6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: one clock = one tick for the main instance.
    task automatic model_step();
        bit [2:0] act;
        bit [2:0] np;
        bit       done;
        if (rst) begin
            m_seg = SEG_CLR; m_age = 0; m_phase = 0; m_first = 1'b1; m_pend = 3'b000;
            return;
        end
        act  = 3'(1 << m_phase);
        done = 1'b0;
        np   = m_pend | (req & ((m_seg == SEG_GRN || m_seg == SEG_BLK || m_seg == SEG_YEL) ? ~act : 3'b111));
        if (m_seg != SEG_FL && !en) begin
            m_seg = SEG_FL; m_age = 0;
        end else if (m_seg == SEG_FL && en) begin
            m_seg = SEG_CLR; m_age = 0; m_phase = 0; m_first = 1'b1;
        end else if (m_seg == SEG_FL) begin
            m_age = (m_age + 1) % 4;
        end else begin
            case (m_seg)
                SEG_CLR: done = (m_age + 1 >= 2);
                SEG_GRN: done = (m_age + 1 >= 8) || (m_age + 1 >= 3 && (m_pend & ~act) != 3'b000);
                SEG_BLK: done = (m_age + 1 >= 8);
                default: done = (m_age + 1 >= 3);
            endcase
            if (done) begin
                m_age = 0;
                case (m_seg)
                    SEG_CLR: begin
                        if (!m_first) m_phase = (m_phase + 1) % 3;
                        m_first = 1'b0;
                        m_seg = SEG_GRN;
                        np[m_phase] = 1'b0;
                    end
                    SEG_GRN: m_seg = SEG_BLK;
                    SEG_BLK: m_seg = SEG_YEL;
                    default: m_seg = SEG_CLR;
                endcase
            end else begin
                m_age++;
            end
        end
        m_pend = np;
    endtask

    function automatic logic [8:0] exp_color();
        logic [8:0] v;
        logic [2:0] g;
        bit         on;
        on = ((m_age / 2) % 2) == 0;
        for (int k = 0; k < 3; k++) begin
            g = 3'b100;
            if (m_seg == SEG_FL) g = on ? 3'b010 : 3'b000;
            else if (k == m_phase) begin
                if (m_seg == SEG_GRN) g = 3'b001;
                else if (m_seg == SEG_BLK) g = on ? 3'b001 : 3'b000;
                else if (m_seg == SEG_YEL) g = 3'b010;
            end
            v[3*k +: 3] = g;
        end
        return v;
    endfunction

    task automatic step();
        int nr;
        int ng;
        logic [1:0] mp;
        @(posedge clk);
        model_step();
        #1;
        mp = m_phase[1:0];
        chk("model_color", color, exp_color());
        chk("model_phase", phase, mp);
        chk("model_flash", flash, m_seg == SEG_FL);
        nr = 0; ng = 0;
        for (int k = 0; k < 3; k++) begin
            if (color[3*k +: 3] != 3'b100) nr++;
            if (color[3*k +: 3] == 3'b001) ng++;
        end
        chk("single_green", ng <= 1, 1'b1);
        if (!flash) chk("single_active", nr <= 1, 1'b1);
    endtask

    initial begin
        logic [2:0] e;
        int         n;
        int         en_cnt;

        // Scenario 1: reset then the first full service of group 0
        rst = 1'b1; en = 1'b1; req = 3'b000;
        step(); step();
        chk("rst_color", color, 9'b100100100);
        chk("rst_phase", phase, 2'd0);
        chk("rst_flash", flash, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            step();
            if (i == 1 || i >= 21) e = 3'b100;
            else if (i <= 9) e = 3'b001;
            else if (i <= 17) e = (((i - 10) / 2) % 2 == 0) ? 3'b001 : 3'b000;
            else e = 3'b010;
            chk("s1_g0", color[2:0], e);
        end
        chk("s1_phase", phase, 2'd1);
        chk("s1_g1", color[5:3], 3'b001);

        // Scenario 2: round-robin service, 21 cycles per group
        repeat (21) step();
        chk("s2_phase2", phase, 2'd2);
        chk("s2_g2", color[8:6], 3'b001);
        repeat (21) step();
        chk("s2_phase0", phase, 2'd0);
        chk("s2_g0", color[2:0], 3'b001);

        // Scenario 3: demand for group 2 shortens greens of groups 0 and 1 only
        req = 3'b100;
        step();
        req = 3'b000;
        for (int s = 2; s <= 48; s++) begin
            step();
            if (s == 11) chk("s3_g0_yellow", color[2:0], 3'b010);
            if (s == 16) begin
                chk("s3_phase1", phase, 2'd1);
                chk("s3_g1_green", color[5:3], 3'b001);
            end
            if (s == 32) chk("s3_g2_green", color[8:6], 3'b001);
            if (s == 48) chk("s3_g2_yellow", color[8:6], 3'b010);
        end

        // Scenario 4: flash mode entered from group 1 yellow
        n = 0;
        while (!(m_seg == SEG_YEL && m_phase == 1) && n < 200) begin step(); n++; end
        chk("s4_reach_yellow1", n < 200, 1'b1);
        en = 1'b0;
        step();
        chk("s4_flash_on", flash, 1'b1);
        chk("s4_flash_lit", color, 9'b010010010);
        for (int j = 1; j <= 9; j++) begin
            step();
            chk("s4_flash_pat", color, (((j / 2) % 2) == 0) ? 9'b010010010 : 9'b000000000);
        end
        en = 1'b1;
        step();
        chk("s4_exit_flash", flash, 1'b0);
        chk("s4_exit_red", color, 9'b100100100);
        chk("s4_exit_phase", phase, 2'd0);
        step();
        chk("s4_red2", color, 9'b100100100);
        step();
        chk("s4_g0_green", color[2:0], 3'b001);

        // Scenario 5: reset mid-green of group 2 discards pending demand
        n = 0;
        while (!(m_seg == SEG_GRN && m_phase == 2) && n < 200) begin step(); n++; end
        chk("s5_reach_green2", n < 200, 1'b1);
        req = 3'b011;
        step();
        req = 3'b000;
        step();
        rst = 1'b1;
        step();
        chk("s5_rst_color", color, 9'b100100100);
        chk("s5_rst_phase", phase, 2'd0);
        rst = 1'b0;
        for (int s = 1; s <= 18; s++) begin
            step();
            if (s == 2) chk("s5_g0_green", color[2:0], 3'b001);
            if (s == 18) chk("s5_g0_yellow_full", color[2:0], 3'b010);
        end

        // Randomized requests, enable drops and occasional resets
        en_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 15) == 0);
            if (en_cnt > 0) begin
                en_cnt--;
                if (en_cnt == 0) en = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                en = 1'b0;
                en_cnt = $urandom_range(1, 12);
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; en = 1'b1; req = 3'b000;

        // Scenario 6: prescaled instance, TICK_DIV=4, no blink phase
        chk("s6_rst_color", color6, 9'b100100100);
        rst6 = 1'b0;
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (color6[2:0] == 3'b001) break;
            n++;
        end
        chk("s6_first_red", n, 8);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (color6[2:0] != 3'b001) break;
            n++;
        end
        chk("s6_green_len", n, 32);
        chk("s6_yellow_after_green", color6[2:0], 3'b010);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (color6[2:0] != 3'b010) break;
            n++;
        end
        chk("s6_yellow_len", n, 12);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (color6[5:3] == 3'b001) break;
            n++;
        end
        chk("s6_clear_len", n, 8);
        chk("s6_phase1", phase6, 2'd1);
        chk("s6_flash", flash6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Parametrised multi-approach intersection controller. It generalises the single-signal light to N_DIR signal groups served round-robin, with green-blink warning, all-red clearance, pedestrian/vehicle demand shortening, and a yellow-flash mode when disabled. All timing is in ticks from an internal prescaler. It sits at the top of the light datapath and drives one-hot lamp vectors per group.

Parameters:
N_DIR, 3, number of signal groups (2..8)
TICK_DIV, 1, clk cycles per tick (>=1)
GREEN_ON, 40, max green duration, ticks (>=1)
MIN_GREEN, 10, minimum green before early termination, ticks (1..GREEN_ON)
BLINK, 3, green-blink flashes before yellow (0 = skip blink phase)
BLINK_HALF, 2, on/off half-period for green blink and flash mode, ticks (>=1)
YELLOW_ON, 5, yellow duration, ticks (>=1)
ALL_RED, 2, all-red clearance duration, ticks (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en_i  in  1  1 = normal cycling; 0 = yellow-flash mode
req_i  in  N_DIR  demand pulse/level per group; latched
color_out  out  3*N_DIR  group k at [3k+2:3k]; 001 GREEN, 010 YELLOW, 100 RED, 000 dark
phase_o  out  max(1,$clog2(N_DIR))  index of active group
flash_o  out  1  high while in FLASH state

Behaviour:
- One clock, rst synchronous active-high, sampled on posedge clk; rst has priority over all other inputs.
- Reset values: state=ALL_RED, phase_o=0, every group 100, flash_o=0, prescaler=0, state timer=0, pending requests=0.
- Prescaler: counts 0..TICK_DIV-1; tick=1 when count==TICK_DIV-1 (TICK_DIV=1 -> tick every cycle). Cleared on reset only.
- State timer counts ticks and clears on every state change. A state of duration D ends on the tick where timer==D-1.
- States: ALL_RED -> GREEN -> GBLINK (skipped if BLINK=0) -> YELLOW -> ALL_RED (phase advances) -> GREEN ...; FLASH is entered from any state.
- ALL_RED: all groups 100 for ALL_RED ticks. On exit, phase_o = (phase_o+1) mod N_DIR. Exception: the first ALL_RED after reset or after leaving FLASH does not advance; phase stays 0.
- GREEN: active group 001, others 100. Exit after GREEN_ON ticks. Early exit occurs at a tick with timer>=MIN_GREEN-1 if any pending request exists for a group other than the active one.
- GBLINK: active group alternates 001 for BLINK_HALF ticks, then 000 for BLINK_HALF ticks, BLINK times. Total 2*BLINK*BLINK_HALF ticks, starting lit.
- YELLOW: active group 010 for YELLOW_ON ticks.
- Requests: req_i[k]=1 sets pending[k], except for the active group while in GREEN/GBLINK/YELLOW. pending[k] clears on the edge that group k enters GREEN. Set and clear on the same edge: clear wins. Requests are retained through FLASH. Service order remains strictly round-robin; requests only shorten green.
- en_i=0 in any non-FLASH state: the next edge enters FLASH, timer clears, and flash_o=1. All groups show 010 for BLINK_HALF ticks, then 000 for BLINK_HALF ticks, repeating, starting lit.
- en_i=1 in FLASH: the next edge enters ALL_RED with phase_o=0, so group 0 is served next. The en_i toggle is honoured regardless of tick alignment.
- Outputs are registered and change on the same edge as the state register; no combinational path from inputs to outputs.
- Exactly one group is ever non-red outside FLASH. GREEN on two groups simultaneously is a design error; the bench asserts against it.

Test Plan:
All scenarios use N_DIR=3, TICK_DIV=1, GREEN_ON=8, MIN_GREEN=3, BLINK=2, BLINK_HALF=2, YELLOW_ON=3, ALL_RED=2 unless noted.
1. Reset release, no req -> all 100 for 2 cycles. Then group0 001 x8, then 001,001,000,000,001,001,000,000, then 010 x3, then all 100 x2, then phase_o=1 and group1 001.
2. Free-run 63 cycles after first green -> groups served 0,1,2,0. Each group occupies 21 cycles (8+8+3+2). Never two groups non-red.
3. req_i[2] pulsed 1 cycle in group0 GREEN cycle 1 -> group0 green lasts 3 cycles. Group1 green also lasts 3 cycles. Group2 green lasts the full 8 cycles; pending[2] is 0 after group2 enters GREEN.
4. en_i=0 for 10 cycles during group1 YELLOW -> next edge flash_o=1, all groups 010,010,000,000,... When en_i=1, next edge all 100 x2, then group0 001.
5. rst pulsed 1 cycle mid-GREEN of group2 with pending[0]=1 -> next edge all 100, phase_o=0, pending cleared. Normal sequence from scenario 1 then follows.
6. TICK_DIV=4 -> first green lasts exactly 32 clk cycles; all-red clearance lasts 8 cycles.
